// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and load/store.
// Define MEM_PORT_ARB_RR_EN for round-robin arbitration; default is fixed data-over-fetch priority.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk_w_i,
  input  logic        res_w_i_l,
  input  logic        if_req_w_i_h,
  input  logic [31:0] if_addr_w_i,
  output logic [31:0] if_rdata_w_o,
  output logic        if_done_w_o_h,
  input  logic        d_req_w_i_h,
  input  logic        d_wr_w_i_h,
  input  logic [31:0] d_addr_w_i,
  input  logic [31:0] d_wdata_w_i,
  input  logic [2:0]  d_byte_sel_w_i,
  output logic [31:0] d_rdata_w_o,
  output logic        d_done_w_o_h,
  output logic        m_req_w_o_h,
  output logic        m_wr_w_o_h,
  output logic [31:0] m_addr_w_o,
  output logic [31:0] m_wdata_w_o,
  output logic [2:0]  m_byte_sel_w_o,
  input  logic        m_ack_w_i_h,
  input  logic [31:0] m_rdata_w_i,
  output logic        busy_w_o_h,
  output logic        timeout_w_o_h
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} state_e;

  localparam bit               TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               m_req_q, m_req_d, m_wr_q, m_wr_d;
  logic [31:0]        m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
  logic [2:0]         m_sel_q, m_sel_d;
  logic [31:0]        if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic               if_done_q, if_done_d, d_done_q, d_done_d;
  logic               busy_q, busy_d, timeout_q, timeout_d;
  logic               pick_d;
`ifdef MEM_PORT_ARB_RR_EN
  logic               last_owner_q, last_owner_d;  // 1 = data served last
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    m_req_d    = m_req_q;
    m_wr_d     = m_wr_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_sel_d    = m_sel_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_done_d  = 1'b0;
    d_done_d   = 1'b0;
    timeout_d  = timeout_q;
`ifdef MEM_PORT_ARB_RR_EN
    last_owner_d = last_owner_q;
    pick_d       = d_req_w_i_h && (!if_req_w_i_h || !last_owner_q);
`else
    pick_d       = d_req_w_i_h;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_d) begin
          state_d   = BUSY_D;
          m_req_d   = 1'b1;
          m_wr_d    = d_wr_w_i_h;
          m_addr_d  = d_addr_w_i;
          m_wdata_d = d_wdata_w_i;
          m_sel_d   = d_byte_sel_w_i;
`ifdef MEM_PORT_ARB_RR_EN
          last_owner_d = 1'b1;
`endif
        end else if (if_req_w_i_h) begin
          state_d   = BUSY_IF;
          m_req_d   = 1'b1;
          m_wr_d    = 1'b0;
          m_addr_d  = if_addr_w_i;
          m_wdata_d = '0;
          m_sel_d   = 3'b010;
`ifdef MEM_PORT_ARB_RR_EN
          last_owner_d = 1'b0;
`endif
        end
      end
      BUSY_IF, BUSY_D: begin
        // ack takes precedence over a timeout expiring in the same cycle
        if (m_ack_w_i_h) begin
          state_d = RESP;
          m_req_d = 1'b0;
          cnt_d   = '0;
          if (state_q == BUSY_IF) begin
            if_rdata_d = m_rdata_w_i;
            if_done_d  = 1'b1;
          end else begin
            if (!m_wr_q) d_rdata_d = m_rdata_w_i;
            d_done_d = 1'b1;
          end
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          state_d   = RESP;
          m_req_d   = 1'b0;
          cnt_d     = '0;
          timeout_d = 1'b1;
          if (state_q == BUSY_IF) begin
            if_rdata_d = '0;
            if_done_d  = 1'b1;
          end else begin
            d_rdata_d = '0;
            d_done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
    if (!res_w_i_l) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      m_req_q    <= 1'b0;
      m_wr_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_sel_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
`ifdef MEM_PORT_ARB_RR_EN
      last_owner_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      m_req_q    <= m_req_d;
      m_wr_q     <= m_wr_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_sel_q    <= m_sel_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_done_q  <= if_done_d;
      d_done_q   <= d_done_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
`ifdef MEM_PORT_ARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  assign if_rdata_w_o   = if_rdata_q;
  assign if_done_w_o_h  = if_done_q;
  assign d_rdata_w_o    = d_rdata_q;
  assign d_done_w_o_h   = d_done_q;
  assign m_req_w_o_h    = m_req_q;
  assign m_wr_w_o_h     = m_wr_q;
  assign m_addr_w_o     = m_addr_q;
  assign m_wdata_w_o    = m_wdata_q;
  assign m_byte_sel_w_o = m_sel_q;
  assign busy_w_o_h     = busy_q;
  assign timeout_w_o_h  = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req, d_req, d_wr, m_ack;
  logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
  logic [2:0]  d_sel;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
  logic        if_done, d_done, m_req, m_wr, busy, tmo;
  logic [2:0]  m_sel;

  mem_port_arbiter #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .clk_w_i(clk), .res_w_i_l(rst_n),
    .if_req_w_i_h(if_req), .if_addr_w_i(if_addr), .if_rdata_w_o(if_rdata), .if_done_w_o_h(if_done),
    .d_req_w_i_h(d_req), .d_wr_w_i_h(d_wr), .d_addr_w_i(d_addr), .d_wdata_w_i(d_wdata),
    .d_byte_sel_w_i(d_sel), .d_rdata_w_o(d_rdata), .d_done_w_o_h(d_done),
    .m_req_w_o_h(m_req), .m_wr_w_o_h(m_wr), .m_addr_w_o(m_addr), .m_wdata_w_o(m_wdata),
    .m_byte_sel_w_o(m_sel), .m_ack_w_i_h(m_ack), .m_rdata_w_i(m_rdata),
    .busy_w_o_h(busy), .timeout_w_o_h(tmo)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Transaction-level model: who is being served, how long it has waited, whether it is responding.
  int          srv;     // 0 none, 1 fetch, 2 data
  bit          resp;
  int          nbusy;
  bit          last_d;
  logic [31:0] e_if_rdata, e_d_rdata, e_m_addr, e_m_wdata;
  logic        e_if_done, e_d_done, e_m_req, e_m_wr, e_busy, e_to;
  logic [2:0]  e_m_sel;

  bit rec = 0;
  int order[$];

  task automatic model_reset();
    srv = 0; resp = 0; nbusy = 0; last_d = 0;
    e_if_rdata = '0; e_d_rdata = '0; e_m_addr = '0; e_m_wdata = '0; e_m_sel = '0;
    e_if_done = 0; e_d_done = 0; e_m_req = 0; e_m_wr = 0; e_busy = 0; e_to = 0;
  endtask

  task automatic finish_txn();
    e_if_done = (srv == 1);
    e_d_done  = (srv == 2);
    e_m_req = 0;
    resp = 1;
    srv = 0;
  endtask

  task automatic model_step();
    bit take_d;
    e_if_done = 0;
    e_d_done  = 0;
    if (resp) begin
      resp = 0;
      e_busy = 0;
    end else if (srv != 0) begin
      nbusy++;
      if (m_ack) begin
        if (srv == 1) e_if_rdata = m_rdata;
        else if (!e_m_wr) e_d_rdata = m_rdata;
        finish_txn();
      end else if (TO != 0 && nbusy == TO) begin
        e_to = 1;
        if (srv == 1) e_if_rdata = '0; else e_d_rdata = '0;
        finish_txn();
      end
    end else if (if_req || d_req) begin
`ifdef MEM_PORT_ARB_RR_EN
      take_d = d_req && !(if_req && last_d);
`else
      take_d = d_req;
`endif
      last_d = take_d;
      if (take_d) begin
        srv = 2; e_m_wr = d_wr; e_m_addr = d_addr; e_m_wdata = d_wdata; e_m_sel = d_sel;
      end else begin
        srv = 1; e_m_wr = 0; e_m_addr = if_addr; e_m_wdata = '0; e_m_sel = 3'b010;
      end
      nbusy = 0;
      e_m_req = 1;
      e_busy = 1;
    end
  endtask

  task automatic check_all();
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("if_done", 32'(if_done), 32'(e_if_done));
    chk("d_rdata", d_rdata, e_d_rdata);
    chk("d_done", 32'(d_done), 32'(e_d_done));
    chk("m_req", 32'(m_req), 32'(e_m_req));
    chk("m_wr", 32'(m_wr), 32'(e_m_wr));
    chk("m_addr", m_addr, e_m_addr);
    chk("m_wdata", m_wdata, e_m_wdata);
    chk("m_sel", 32'(m_sel), 32'(e_m_sel));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("timeout", 32'(tmo), 32'(e_to));
    if (rec && d_done) order.push_back(1);
    if (rec && if_done) order.push_back(0);
  endtask

  // Called at a falling edge: drive inputs for the coming rising edge, advance model, check next cycle.
  task automatic tick(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [31:0] da, input logic [31:0] dwd, input logic [2:0] ds,
                      input logic ack, input logic [31:0] rd);
    if_req = ir; if_addr = ia; d_req = dr; d_wr = dw; d_addr = da; d_wdata = dwd; d_sel = ds;
    m_ack = ack; m_rdata = rd;
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [31:0] saved;
    int          nreq;
    int          exp_order[3];
    logic        ip, dp, dw;
    logic [31:0] ia, da, dd;
    logic [2:0]  ds;

    if_req = 0; if_addr = '0; d_req = 0; d_wr = 0; d_addr = '0; d_wdata = '0; d_sel = '0;
    m_ack = 0; m_rdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1;

    // contention: both requesters held, immediate ack
    rec = 1;
    for (int t = 0; t < 3; t++) begin
      tick(1, 32'h1000, 1, 0, 32'h2000, '0, 3'b010, 0, '0);
      tick(1, 32'h1000, 1, 0, 32'h2000, '0, 3'b010, 1, 32'h1111_0000 + 32'(t));
      tick(1, 32'h1000, 1, 0, 32'h2000, '0, 3'b010, 0, '0);
    end
    rec = 0;
`ifdef MEM_PORT_ARB_RR_EN
    exp_order = '{1, 0, 1};
`else
    exp_order = '{1, 1, 1};
`endif
    chk("order_len", 32'(order.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("order", (i < order.size()) ? 32'(order[i]) : 32'hFFFF_FFFF, 32'(exp_order[i]));

    // fetch with ack on 2nd busy cycle, stray ack during RESP and in IDLE
    tick(1, 32'h100, 0, 0, '0, '0, '0, 0, '0);
    chk("fetch_m_addr", m_addr, 32'h100);
    chk("fetch_m_wr", 32'(m_wr), 32'd0);
    tick(1, 32'h100, 0, 0, '0, '0, '0, 0, '0);
    tick(1, 32'h100, 0, 0, '0, '0, '0, 1, 32'hDEAD_BEEF);
    chk("fetch_done", 32'(if_done), 32'd1);
    chk("fetch_rdata", if_rdata, 32'hDEAD_BEEF);
    tick(0, '0, 0, 0, '0, '0, '0, 1, 32'h5555_5555);
    chk("fetch_done_once", 32'(if_done), 32'd0);
    chk("fetch_busy_off", 32'(busy), 32'd0);
    tick(0, '0, 0, 0, '0, '0, '0, 1, 32'h6666_6666);
    chk("stray_idle_rdata", if_rdata, 32'hDEAD_BEEF);

    // store
    saved = e_d_rdata;
    tick(0, '0, 1, 1, 32'h200, 32'h1234_5678, 3'b000, 0, '0);
    chk("st_m_wr", 32'(m_wr), 32'd1);
    chk("st_m_addr", m_addr, 32'h200);
    chk("st_m_wdata", m_wdata, 32'h1234_5678);
    chk("st_m_sel", 32'(m_sel), 32'd0);
    tick(0, '0, 1, 1, 32'h200, 32'h1234_5678, 3'b000, 1, 32'hAAAA_AAAA);
    chk("st_done", 32'(d_done), 32'd1);
    chk("st_rdata_kept", d_rdata, saved);
    tick(0, '0, 0, 0, '0, '0, '0, 0, '0);

    // timeout with no ack
    nreq = 0;
    tick(0, '0, 1, 0, 32'h300, '0, 3'b010, 0, '0);
    nreq += int'(m_req);
    for (int i = 0; i < 4; i++) begin
      tick(0, '0, 1, 0, 32'h300, '0, 3'b010, 0, '0);
      nreq += int'(m_req);
    end
    chk("to_done", 32'(d_done), 32'd1);
    chk("to_rdata", d_rdata, 32'd0);
    chk("to_flag", 32'(tmo), 32'd1);
    tick(0, '0, 0, 0, '0, '0, '0, 0, '0);
    nreq += int'(m_req);
    chk("to_mreq_cycles", 32'(nreq), 32'(TO));

    // random traffic
    ip = 0; dp = 0; dw = 0; ia = '0; da = '0; dd = '0; ds = '0;
    for (int c = 0; c < 1500; c++) begin
      if (e_if_done) ip = 0;
      if (e_d_done) dp = 0;
      if (!ip && $urandom_range(2) == 0) begin ip = 1; ia = $urandom; end
      if (!dp && $urandom_range(2) == 0) begin
        dp = 1; dw = 1'($urandom_range(1)); da = $urandom; dd = $urandom; ds = 3'($urandom_range(7));
      end
      tick(ip, ia, dp, dw, da, dd, ds, ($urandom_range(3) == 0), $urandom);
    end
    chk("to_sticky", 32'(tmo), 32'd1);

    // drain, then asynchronous reset in the middle of a data access
    repeat (8) tick(0, '0, 0, 0, '0, '0, '0, 0, '0);
    tick(0, '0, 1, 0, 32'h400, '0, 3'b010, 0, '0);
    tick(0, '0, 1, 0, 32'h400, '0, 3'b010, 0, '0);
    rst_n = 0;
    #1;
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_d_done", 32'(d_done), 32'd0);
    d_req = 0;
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1;
    tick(1, 32'h500, 0, 0, '0, '0, '0, 0, '0);
    tick(1, 32'h500, 0, 0, '0, '0, '0, 1, 32'hCAFE_F00D);
    chk("post_rst_done", 32'(if_done), 32'd1);
    chk("post_rst_rdata", if_rdata, 32'hCAFE_F00D);
    chk("post_rst_to", 32'(tmo), 32'd0);
    tick(0, '0, 0, 0, '0, '0, '0, 0, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
